// File: rtl/ledpanel_blitter.sv
// ledpanel_blitter: bus-mapped rectangle filler for the LED panel.
// Firmware loads two corners and a colour, then writes CTRL to start the fill.
// The fill emits one pixel per clock in row-major order from (x0,y0).
//
// state | meaning
// IDLE  | bus registers writable, no pixel writes
// FILL  | one pixel per clock; writes to registers 0-3 stall until IDLE
module ledpanel_blitter #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [2:0]        bus_addr,
    input  logic [3:0]        bus_wstrb,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              wr_enable,
    output logic [X_BITS-1:0] wr_addr_x,
    output logic [Y_BITS-1:0] wr_addr_y,
    output logic [23:0]       wr_rgb_data
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [X_BITS-1:0] x0, x1, cx;
    logic [Y_BITS-1:0] y0, y1, cy;
    logic [23:0]       color;
    logic [15:0]       last_fill_count;
    logic [CNT_W-1:0]  total;

    logic              is_write;
    logic              accept;
    logic              take;
    logic              fill_active;
    logic              fill_last;
    logic              busy_next;
    logic [15:0]       count_next;
    logic [CNT_W-1:0]  total_next;
    logic              rect_ok;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    // Request acceptance and look-ahead status. Reads report the values that
    // will hold after the current edge, so a CTRL read that coincides with the
    // final pixel already sees busy=0 and the final count.
    always_comb begin
        is_write    = |bus_wstrb;
        accept      = !is_write || bus_addr[2] || (state == IDLE);
        take        = bus_valid && !bus_ready && accept;
        fill_active = (state == FILL);
        fill_last   = fill_active && (cx == x1) && (cy == y1);
        busy_next   = fill_active && !fill_last;
        count_next  = last_fill_count + 16'(fill_active);
        total_next  = total + CNT_W'(fill_active);
        rect_ok     = (x0 <= x1) && (y0 <= y1);
    end

    // Register read multiplexer; unused bits and unmapped indices read zero.
    always_comb begin
        rd_val = '0;
        case (bus_addr)
            3'd0: begin
                rd_val[X_BITS-1:0]   = x0;
                rd_val[Y_BITS+7:8]   = y0;
            end
            3'd1: begin
                rd_val[X_BITS-1:0]   = x1;
                rd_val[Y_BITS+7:8]   = y1;
            end
            3'd2:    rd_val[23:0]      = color;
            3'd3:    rd_val            = {busy_next, 15'b0, count_next};
            3'd4:    rd_val[CNT_W-1:0] = total_next;
            default: rd_val            = '0;
        endcase
    end

    // Only the decoded fields of the write data are stored.
    assign unused_wdata = ^bus_wdata;

    // Bus handshake, register file and fill FSM share one block because the
    // CTRL write and the fill both update last_fill_count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus_ready       <= 1'b0;
            bus_rdata       <= '0;
            wr_enable       <= 1'b0;
            wr_addr_x       <= '0;
            wr_addr_y       <= '0;
            wr_rgb_data     <= '0;
            x0              <= '0;
            y0              <= '0;
            x1              <= '0;
            y1              <= '0;
            cx              <= '0;
            cy              <= '0;
            color           <= '0;
            last_fill_count <= '0;
            total           <= '0;
        end else begin
            bus_ready <= take;
            if (take) begin
                bus_rdata <= is_write ? 32'd0 : rd_val;
            end

            wr_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && is_write && bus_addr == 3'd3) begin
                        last_fill_count <= '0;
                        if (rect_ok) begin
                            cx    <= x0;
                            cy    <= y0;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    wr_enable       <= 1'b1;
                    wr_addr_x       <= cx;
                    wr_addr_y       <= cy;
                    wr_rgb_data     <= color;
                    last_fill_count <= count_next;
                    total           <= total_next;
                    if (cx != x1) begin
                        cx <= cx + 1'b1;
                    end else begin
                        cx <= x0;
                        if (cy == y1) begin
                            state <= IDLE;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Writes to 0-2 are only accepted in IDLE, so they never disturb a fill.
            if (take && is_write) begin
                case (bus_addr)
                    3'd0: begin
                        if (bus_wstrb[0]) x0 <= bus_wdata[X_BITS-1:0];
                        if (bus_wstrb[1]) y0 <= bus_wdata[Y_BITS+7:8];
                    end
                    3'd1: begin
                        if (bus_wstrb[0]) x1 <= bus_wdata[X_BITS-1:0];
                        if (bus_wstrb[1]) y1 <= bus_wdata[Y_BITS+7:8];
                    end
                    3'd2: begin
                        for (int b = 0; b < 3; b++) begin
                            if (bus_wstrb[b]) color[8*b +: 8] <= bus_wdata[8*b +: 8];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ledpanel_blitter.sv
// Directed testbench for ledpanel_blitter.
module tb_ledpanel_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_valid;
    logic        bus_ready;
    logic [2:0]  bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        wr_enable;
    logic [4:0]  wr_addr_x;
    logic [4:0]  wr_addr_y;
    logic [23:0] wr_rgb_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          px_cyc[$];
    int          px_x[$];
    int          px_y[$];
    logic [23:0] px_rgb[$];

    ledpanel_blitter #(.X_BITS(5), .Y_BITS(5), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .wr_enable  (wr_enable),
        .wr_addr_x  (wr_addr_x),
        .wr_addr_y  (wr_addr_y),
        .wr_rgb_data(wr_rgb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pixel monitor: records every emitted pixel with the edge number that produced it.
    always @(negedge clk) begin
        if (wr_enable === 1'b1) begin
            px_cyc.push_back(cyc);
            px_x.push_back(int'(wr_addr_x));
            px_y.push_back(int'(wr_addr_y));
            px_rgb.push_back(wr_rgb_data);
        end
    end

    task automatic clear_pixels();
        px_cyc.delete();
        px_x.delete();
        px_y.delete();
        px_rgb.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus transaction; take_cyc is the edge at which the request was taken.
    task automatic bus_xfer(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] rd, output int take_cyc);
        bus_valid = 1'b1;
        bus_addr  = a;
        bus_wstrb = s;
        bus_wdata = d;
        take_cyc  = -1;
        rd        = '0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (bus_ready === 1'b1) begin
                rd       = bus_rdata;
                take_cyc = cyc;
                break;
            end
        end
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        if (take_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout addr=%0d no bus_ready within 3000 cycles", a);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int t;
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wstrb = '0;
        bus_wdata = '0;
        wait_cycles(3);
        checks++;
        if ({bus_ready, wr_enable, bus_rdata, wr_addr_x, wr_addr_y, wr_rgb_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b rdata=%h x=%0d y=%0d rgb=%h want all 0",
                     bus_ready, wr_enable, bus_rdata, wr_addr_x, wr_addr_y, wr_rgb_data);
        end
        reset = 1'b0;
        bus_xfer(3'd4, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_total got %h want 00000000", rd); end
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 00000000", rd); end
    endtask

    task automatic test_quad();
        logic [31:0] rd;
        int t, k, bad;
        int ex[4] = '{0, 1, 0, 1};
        int ey[4] = '{0, 0, 1, 1};
        bus_xfer(3'd0, 4'hF, 32'h0000_0000, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_0101, rd, t);
        bus_xfer(3'd2, 4'hF, 32'h00FF_0000, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (t !== k + 2 || rd !== 32'h8000_0002) begin
            errors++;
            $display("FAIL quad_ctrl_busy got edge=%0d rd=%h want edge=%0d rd=80000002", t - k, rd, 2);
        end
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (t !== k + 4 || rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL quad_ctrl_done got edge=%0d rd=%h want edge=%0d rd=00000004", t - k, rd, 4);
        end
        wait_cycles(5);
        checks++;
        if (px_cyc.size() !== 4) begin
            errors++;
            $display("FAIL quad_count got %0d pixels want 4", px_cyc.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++)
                if (px_cyc[i] != k + 1 + i || px_x[i] != ex[i] || px_y[i] != ey[i] || px_rgb[i] !== 24'hFF0000)
                    bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL quad_pixels got %0d wrong pixels want 0", bad);
            end
        end
        checks++;
        if (wr_enable !== 1'b0 || wr_addr_x !== 5'd1 || wr_addr_y !== 5'd1 || wr_rgb_data !== 24'hFF0000) begin
            errors++;
            $display("FAIL quad_hold got we=%b x=%0d y=%0d rgb=%h want we=0 x=1 y=1 rgb=ff0000",
                     wr_enable, wr_addr_x, wr_addr_y, wr_rgb_data);
        end
    endtask

    task automatic test_full_panel();
        logic [31:0] rd;
        int t, k, bad;
        do_reset();
        bus_xfer(3'd1, 4'hF, 32'h0000_1F1F, rd, t);
        bus_xfer(3'd2, 4'hF, 32'h0000_00FF, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        wait_cycles(1030);
        checks++;
        if (px_cyc.size() !== 1024) begin
            errors++;
            $display("FAIL full_count got %0d pixels want 1024", px_cyc.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (px_cyc[i] != k + 1 + i || px_x[i] != i % 32 || px_y[i] != i / 32 || px_rgb[i] !== 24'h0000FF)
                    bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_order got %0d wrong pixels want 0", bad);
            end
        end
        checks++;
        if (wr_addr_x !== 5'd31 || wr_addr_y !== 5'd31) begin
            errors++;
            $display("FAIL full_last got x=%0d y=%0d want x=31 y=31", wr_addr_x, wr_addr_y);
        end
        bus_xfer(3'd4, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'd1024) begin errors++; $display("FAIL full_total got %h want 00000400", rd); end
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'd1024) begin errors++; $display("FAIL full_ctrl got %h want 00000400", rd); end
    endtask

    task automatic test_degenerate();
        logic [31:0] rd;
        int t, k;
        bus_xfer(3'd0, 4'hF, 32'h0000_0005, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_0003, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        wait_cycles(10);
        checks++;
        if (px_cyc.size() !== 0) begin errors++; $display("FAIL degen_x_count got %0d pixels want 0", px_cyc.size()); end
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL degen_x_ctrl got %h want 00000000", rd); end

        bus_xfer(3'd0, 4'hF, 32'h0000_0300, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_0102, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        wait_cycles(10);
        checks++;
        if (px_cyc.size() !== 0) begin errors++; $display("FAIL degen_y_count got %0d pixels want 0", px_cyc.size()); end

        bus_xfer(3'd0, 4'hF, 32'h0000_0A07, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_0A07, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        wait_cycles(5);
        checks++;
        if (px_cyc.size() !== 1 || px_cyc[0] != k + 1 || px_x[0] != 7 || px_y[0] != 10) begin
            errors++;
            $display("FAIL single_pixel got n=%0d want n=1 at (7,10) edge k+1", px_cyc.size());
        end
    endtask

    task automatic test_stall_write();
        logic [31:0] rd;
        int t, k, bad;
        bus_xfer(3'd0, 4'hF, 32'h0000_0000, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_0003, rd, t);
        bus_xfer(3'd2, 4'hF, 32'h0000_00FF, rd, t);
        clear_pixels();
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        bus_xfer(3'd2, 4'hF, 32'h0000_FF00, rd, t);
        checks++;
        if (t !== k + 5) begin errors++; $display("FAIL stall_ack got edge k+%0d want k+5", t - k); end
        wait_cycles(3);
        bad = 0;
        for (int i = 0; i < px_cyc.size(); i++)
            if (px_rgb[i] !== 24'h0000FF || px_x[i] != i || px_y[i] != 0) bad++;
        checks++;
        if (px_cyc.size() !== 4 || bad != 0) begin
            errors++;
            $display("FAIL stall_pixels got n=%0d bad=%0d want n=4 bad=0", px_cyc.size(), bad);
        end
        bus_xfer(3'd2, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0000_FF00) begin errors++; $display("FAIL stall_color got %h want 0000ff00", rd); end
    endtask

    task automatic test_read_during_fill();
        logic [31:0] rd;
        int t, k;
        bus_xfer(3'd1, 4'hF, 32'h0000_0107, rd, t);
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (t !== k + 2 || rd[31] !== 1'b1) begin
            errors++;
            $display("FAIL busy_read got edge k+%0d bit31=%b want k+2 bit31=1", t - k, rd[31]);
        end
        bus_xfer(3'd6, 4'h0, 32'h0, rd, t);
        checks++;
        if (t !== k + 4 || rd !== 32'h0) begin
            errors++;
            $display("FAIL idx6_read got edge k+%0d rd=%h want k+4 rd=00000000", t - k, rd);
        end
        bus_xfer(3'd4, 4'hF, 32'hFFFF_FFFF, rd, t);
        checks++;
        if (t !== k + 6) begin errors++; $display("FAIL total_write_ack got edge k+%0d want k+6", t - k); end
        wait_cycles(20);
        bus_xfer(3'd3, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'd16) begin errors++; $display("FAIL fill16_ctrl got %h want 00000010", rd); end
        bus_xfer(3'd4, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'd1045) begin errors++; $display("FAIL total_accum got %0d want 1045", rd); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd;
        int t;
        bus_xfer(3'd2, 4'hF, 32'hFFFF_FFFF, rd, t);
        bus_xfer(3'd2, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h00FF_FFFF) begin errors++; $display("FAIL color_mask got %h want 00ffffff", rd); end
        bus_xfer(3'd2, 4'hF, 32'h0012_3456, rd, t);
        bus_xfer(3'd2, 4'h2, 32'h0000_AB00, rd, t);
        bus_xfer(3'd2, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0012_AB56) begin errors++; $display("FAIL color_strobe got %h want 0012ab56", rd); end
        bus_xfer(3'd0, 4'hF, 32'hFFFF_FFFF, rd, t);
        bus_xfer(3'd0, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0000_1F1F) begin errors++; $display("FAIL p0_mask got %h want 00001f1f", rd); end
        bus_xfer(3'd0, 4'h1, 32'h0000_0002, rd, t);
        bus_xfer(3'd0, 4'h0, 32'h0, rd, t);
        checks++;
        if (rd !== 32'h0000_1F02) begin errors++; $display("FAIL p0_strobe got %h want 00001f02", rd); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int t, k;
        logic [2:0] addrs[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        bus_xfer(3'd0, 4'hF, 32'h0000_0000, rd, t);
        bus_xfer(3'd1, 4'hF, 32'h0000_1F1F, rd, t);
        bus_xfer(3'd2, 4'hF, 32'h0012_3456, rd, t);
        bus_xfer(3'd3, 4'hF, 32'h1, rd, k);
        wait_cycles(20);
        checks++;
        if (wr_enable !== 1'b1) begin errors++; $display("FAIL midfill_active got we=%b want 1", wr_enable); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_enable !== 1'b0) begin errors++; $display("FAIL reset_abort got we=%b want 0", wr_enable); end
        reset = 1'b0;
        clear_pixels();
        wait_cycles(20);
        checks++;
        if (px_cyc.size() !== 0) begin errors++; $display("FAIL reset_no_pixels got %0d want 0", px_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            bus_xfer(addrs[i], 4'h0, 32'h0, rd, t);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 00000000", addrs[i], rd); end
        end
    endtask

    initial begin
        test_reset();
        test_quad();
        test_full_panel();
        test_degenerate();
        test_stall_write();
        test_read_during_fill();
        test_byte_strobe();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
